triad_uart_arbiter: RTL and testbench

Shares the single `serial_transmitter` (UART) among up to `NB_TRIADS` `triad_manager` instances in `receivers_top_level`. Each triad raises `data_avl` with a 102-bit `sensor_iterations` payload. The arbiter grants triads round-robin, latches the granted payload, and presents it to the UART together with the triad index. It relays the UART's `reset_parser` completion back to the granted triad. A watchdog releases the grant if the UART never completes.

---
 rtl/triad_uart_arbiter_pkg.sv | 16 +
 rtl/triad_uart_arbiter_if.sv | 28 ++
 rtl/triad_uart_arbiter_rr_picker.sv | 28 ++
 rtl/triad_uart_arbiter.sv | 112 +++++++++++
 tb/tb_triad_uart_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/triad_uart_arbiter_pkg.sv
// Shared types and constants for the triad-to-UART arbiter.
package vive_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SEND  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam int PAYLOAD_W      = 102;
  localparam int TRIAD_ID_W     = 2;
  localparam int DROP_W         = 8;
  localparam int TIMEOUT_CYCLES = 24000;  // 2 ms at 12 MHz

endpackage

// File: rtl/triad_uart_arbiter_if.sv
// Bus bundle between the triad managers, the arbiter and the serial transmitter.
interface triad_uart_arbiter_if #(
  parameter int NB_TRIADS = 4,
  parameter int PAYLOAD_W = vive_pkg::PAYLOAD_W
);
  logic [NB_TRIADS-1:0]             data_avl_in;
  logic [NB_TRIADS*PAYLOAD_W-1:0]   sensor_iterations_in;
  logic [NB_TRIADS-1:0]             reset_parser_out;
  logic                             data_availible_out;
  logic [PAYLOAD_W-1:0]             sensor_iterations_out;
  logic [vive_pkg::TRIAD_ID_W-1:0]  triad_id;
  logic                             reset_parser_in;
  logic [vive_pkg::DROP_W-1:0]      drop_count;

  // arbiter side
  modport master (
    input  data_avl_in, sensor_iterations_in, reset_parser_in,
    output reset_parser_out, data_availible_out, sensor_iterations_out,
           triad_id, drop_count
  );

  // triads + UART side
  modport slave (
    output data_avl_in, sensor_iterations_in, reset_parser_in,
    input  reset_parser_out, data_availible_out, sensor_iterations_out,
           triad_id, drop_count
  );
endinterface

// File: rtl/triad_uart_arbiter_rr_picker.sv
// Combinational round-robin search: first set request above last_grant, wrapping.
module rr_picker
  import vive_pkg::*;
#(
  parameter int NB_TRIADS = 4
) (
  input  logic [NB_TRIADS-1:0]  req_s,
  input  logic [TRIAD_ID_W-1:0] last_grant,
  output logic                  any,
  output logic [TRIAD_ID_W-1:0] pick
);
  localparam int SEL_W = (NB_TRIADS > 1) ? $clog2(NB_TRIADS) : 1;

  // Walk candidates from farthest to nearest so the nearest set bit wins.
  always_comb begin
    int idx;
    idx  = 0;
    any  = 1'b0;
    pick = '0;
    for (int k = NB_TRIADS; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NB_TRIADS;
      if (req_s[idx[SEL_W-1:0]]) begin
        any  = 1'b1;
        pick = TRIAD_ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/triad_uart_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among the triad managers.
//   state | meaning
//   IDLE  | waiting for a synchronised request
//   LATCH | capturing the granted payload and id
//   SEND  | frame offered to the UART, watchdog running
//   ACK   | acknowledging the granted triad until its request drops
module triad_uart_arbiter #(
  parameter int NB_TRIADS      = 4,
  parameter int PAYLOAD_W      = vive_pkg::PAYLOAD_W,
  parameter int TIMEOUT_CYCLES = vive_pkg::TIMEOUT_CYCLES
) (
  input logic                  clk_12MHz,
  input logic                  rst_n,
  triad_uart_arbiter_if.master bus
);
  import vive_pkg::*;

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nx;
  logic [NB_TRIADS-1:0]  req_meta, req_s, grant_vec;
  logic [TRIAD_ID_W-1:0] grant, last_grant, pick;
  logic                  any, req_granted, expired;
  logic [TMR_W-1:0]      timer;
  logic [PAYLOAD_W-1:0]  payload_sel;

  rr_picker #(.NB_TRIADS(NB_TRIADS)) u_picker (
    .req_s      (req_s),
    .last_grant (last_grant),
    .any        (any),
    .pick       (pick)
  );

  assign grant_vec   = NB_TRIADS'(1) << grant;
  assign req_granted = |(req_s & grant_vec);

  // Select the granted triad's slice with constant part-selects only.
  always_comb begin
    payload_sel = '0;
    for (int i = 0; i < NB_TRIADS; i++) begin
      if (grant == TRIAD_ID_W'(i)) payload_sel = bus.sensor_iterations_in[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  // Next-state logic; completion takes priority over watchdog expiry.
  always_comb begin
    state_nx = state;
    expired  = 1'b0;
    case (state)
      IDLE:  if (any) state_nx = LATCH;
      LATCH: state_nx = SEND;
      SEND: begin
        if (bus.reset_parser_in) begin
          state_nx = ACK;
        end else if (timer == TMR_LAST) begin
          expired  = 1'b1;
          state_nx = ACK;
        end
      end
      ACK:   if (!req_granted && !bus.reset_parser_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request synchroniser and state register.
  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      req_meta <= '0;
      req_s    <= '0;
      state    <= IDLE;
    end else begin
      req_meta <= bus.data_avl_in;
      req_s    <= req_meta;
      state    <= state_nx;
    end
  end

  // Grant bookkeeping, payload capture, watchdog and drop counter.
  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      grant                     <= '0;
      last_grant                <= TRIAD_ID_W'(NB_TRIADS - 1);
      timer                     <= '0;
      bus.sensor_iterations_out <= '0;
      bus.triad_id              <= '0;
      bus.drop_count            <= '0;
    end else begin
      if (state == IDLE && any) grant <= pick;
      if (state == LATCH) begin
        bus.sensor_iterations_out <= payload_sel;
        bus.triad_id              <= grant;
        timer                     <= '0;
      end else if (state == SEND) begin
        timer <= timer + TMR_W'(1);
      end
      if (expired && bus.drop_count != '1) bus.drop_count <= bus.drop_count + DROP_W'(1);
      if (state == ACK && state_nx == IDLE) last_grant <= grant;
    end
  end

  // Handshake outputs registered from the next state so they are glitch-free.
  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_availible_out <= 1'b0;
      bus.reset_parser_out   <= '0;
    end else begin
      bus.data_availible_out <= (state_nx == SEND);
      bus.reset_parser_out   <= (state_nx == ACK) ? grant_vec : '0;
    end
  end
endmodule

// File: tb/tb_triad_uart_arbiter.sv
// Directed bench for triad_uart_arbiter with a short watchdog.
module tb_triad_uart_arbiter;
  localparam int N  = 4;
  localparam int PW = 102;
  localparam int T  = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [PW-1:0] pl [N];

  typedef struct {
    logic [N-1:0] req;
    logic [1:0]   id;
  } vec_t;
  vec_t tbl [8];

  triad_uart_arbiter_if #(.NB_TRIADS(N), .PAYLOAD_W(PW)) bus ();

  triad_uart_arbiter #(.NB_TRIADS(N), .PAYLOAD_W(PW), .TIMEOUT_CYCLES(T)) dut (
    .clk_12MHz (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_dav(input logic level, input int budget);
    int n;
    n = 0;
    while (bus.data_availible_out !== level && n < budget) begin
      step();
      n++;
    end
    check("wait_dav", 128'(bus.data_availible_out), 128'(level));
  endtask

  task automatic wait_rpo_clear(input int budget);
    int n;
    n = 0;
    while (bus.reset_parser_out !== '0 && n < budget) begin
      step();
      n++;
    end
    check("wait_ack_clear", 128'(bus.reset_parser_out), 128'(0));
  endtask

  task automatic pulse_done();
    bus.reset_parser_in = 1'b1;
    step();
    bus.reset_parser_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] onehot;
    int n;
    int exp_drop;

    pl[0] = 102'h2A5;
    pl[1] = 102'h1234_5678_9ABC_DEF0_1357;
    pl[2] = 102'hAAAA_5555_AAAA_5555_0F0F_F0F0;
    pl[2][101] = 1'b1;
    pl[3] = 102'hDEAD_BEEF_CAFE_F00D;
    bus.sensor_iterations_in = {pl[3], pl[2], pl[1], pl[0]};
    bus.data_avl_in     = '0;
    bus.reset_parser_in = 1'b0;

    tbl[0] = '{4'b0001, 2'd0};
    tbl[1] = '{4'b1111, 2'd1};
    tbl[2] = '{4'b1111, 2'd2};
    tbl[3] = '{4'b1010, 2'd3};
    tbl[4] = '{4'b1010, 2'd1};
    tbl[5] = '{4'b0100, 2'd2};
    tbl[6] = '{4'b1001, 2'd3};
    tbl[7] = '{4'b1001, 2'd0};

    // reset state
    step();
    step();
    check("rst_dav", 128'(bus.data_availible_out), 0);
    check("rst_ack", 128'(bus.reset_parser_out), 0);
    check("rst_id", 128'(bus.triad_id), 0);
    check("rst_payload", 128'(bus.sensor_iterations_out), 0);
    check("rst_drop", 128'(bus.drop_count), 0);
    rst_n = 1'b1;
    step();

    // table: latency, grant order, payload, acknowledge
    for (int e = 0; e < 8; e++) begin
      bus.data_avl_in = tbl[e].req;
      step(); step(); step();
      check("lat_edge3_low", 128'(bus.data_availible_out), 0);
      step();
      check("lat_edge4_high", 128'(bus.data_availible_out), 1);
      check("tbl_id", 128'(bus.triad_id), 128'(tbl[e].id));
      check("tbl_payload", 128'(bus.sensor_iterations_out), 128'(pl[tbl[e].id]));
      pulse_done();
      onehot = N'(1) << tbl[e].id;
      check("tbl_ack", 128'(bus.reset_parser_out), 128'(onehot));
      check("tbl_dav_low", 128'(bus.data_availible_out), 0);
      bus.data_avl_in = '0;
      wait_rpo_clear(8);
    end

    // watchdog expiry
    bus.data_avl_in = 4'b0100;
    wait_dav(1'b1, 10);
    n = 0;
    while (bus.data_availible_out === 1'b1 && n < T + 10) begin
      step();
      n++;
    end
    check("wd_fall_cycles", 128'(n), 128'(T));
    check("wd_drop1", 128'(bus.drop_count), 1);
    check("wd_ack", 128'(bus.reset_parser_out), 128'(4'b0100));
    bus.data_avl_in = '0;
    wait_rpo_clear(8);

    // completion coincides with expiry
    bus.data_avl_in = 4'b0100;
    wait_dav(1'b1, 10);
    repeat (T - 1) step();
    check("sim_dav_still_high", 128'(bus.data_availible_out), 1);
    pulse_done();
    check("sim_drop_unchanged", 128'(bus.drop_count), 1);
    check("sim_ack", 128'(bus.reset_parser_out), 128'(4'b0100));
    bus.data_avl_in = '0;
    wait_rpo_clear(8);

    // saturation over 300 timeouts
    exp_drop = 1;
    for (int k = 0; k < 300; k++) begin
      bus.data_avl_in = 4'b0001;
      wait_dav(1'b1, 10);
      wait_dav(1'b0, T + 5);
      if (exp_drop < 255) exp_drop++;
      check("sat_drop", 128'(bus.drop_count), 128'(exp_drop));
      bus.data_avl_in = '0;
      wait_rpo_clear(8);
    end

    // reset during SEND
    bus.data_avl_in = 4'b0001;
    wait_dav(1'b1, 10);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_dav", 128'(bus.data_availible_out), 0);
    check("mid_rst_ack", 128'(bus.reset_parser_out), 0);
    check("mid_rst_id", 128'(bus.triad_id), 0);
    check("mid_rst_payload", 128'(bus.sensor_iterations_out), 0);
    check("mid_rst_drop", 128'(bus.drop_count), 0);
    bus.data_avl_in = 4'b1100;
    step();
    rst_n = 1'b1;
    wait_dav(1'b1, 10);
    check("post_rst_id", 128'(bus.triad_id), 2);
    check("post_rst_payload", 128'(bus.sensor_iterations_out), 128'(pl[2]));

    // acknowledge held while request stays high, then back-to-back grant
    pulse_done();
    check("hold_ack_first", 128'(bus.reset_parser_out), 128'(4'b0100));
    for (int c = 0; c < 20; c++) begin
      step();
      check("hold_ack", 128'(bus.reset_parser_out), 128'(4'b0100));
      check("hold_no_grant", 128'(bus.data_availible_out), 0);
    end
    bus.data_avl_in = 4'b1000;
    step();
    check("drop_sync1_ack", 128'(bus.reset_parser_out), 128'(4'b0100));
    step();
    check("drop_sync2_ack", 128'(bus.reset_parser_out), 128'(4'b0100));
    step();
    check("drop_ack_clear", 128'(bus.reset_parser_out), 0);
    step();
    check("b2b_latch_low", 128'(bus.data_availible_out), 0);
    step();
    check("b2b_send_high", 128'(bus.data_availible_out), 1);
    check("b2b_id", 128'(bus.triad_id), 3);
    check("b2b_payload", 128'(bus.sensor_iterations_out), 128'(pl[3]));
    pulse_done();
    bus.data_avl_in = '0;
    wait_rpo_clear(8);

    // fairness: all four continuously requesting, 10-cycle UART
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.data_avl_in = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      wait_dav(1'b1, 20);
      check("rr_id", 128'(bus.triad_id), 128'(f % 4));
      check("rr_payload", 128'(bus.sensor_iterations_out), 128'(pl[f % 4]));
      repeat (10) step();
      pulse_done();
      onehot = N'(1) << (f % 4);
      check("rr_ack", 128'(bus.reset_parser_out), 128'(onehot));
      bus.data_avl_in[f % 4] = 1'b0;
      wait_rpo_clear(10);
      bus.data_avl_in[f % 4] = 1'b1;
    end
    bus.data_avl_in = '0;
    check("rr_drop_none", 128'(bus.drop_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
